// File: rtl/bus_uart_tx.sv
// Bridge-bus UART transmitter: byte FIFO, 8N1 serial framing, drain interrupt.
// Define BUS_UART_TX_PARITY_EN for 8E1/8O1 framing with a CTRL parity-select bit.
module bus_uart_tx #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd2604
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq,
  output logic        tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef BUS_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_ovf, r_ien, w_odd;
  logic [15:0]   r_div;
  state_t        r_state, w_state_nxt;
  logic [15:0]   r_timer, w_timer_nxt, w_div_m1;
  logic [2:0]    r_bitcnt, w_bitcnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt, w_head;
  logic          r_par, w_par_nxt;
  logic          r_tx, w_tx_nxt, r_irq, w_irq_nxt;
  logic          w_wr_data, w_wr_stat, w_wr_ctrl, w_wr_div, w_flush;
  logic          w_full, w_empty, w_push, w_pop, w_can_pop, w_tick, w_ien_nxt;
  logic [4:0]    w_cnt5;
  logic          w_unused;

  assign w_wr_data = we & (addr[3:2] == 2'd0);
  assign w_wr_stat = we & (addr[3:2] == 2'd1);
  assign w_wr_ctrl = we & (addr[3:2] == 2'd2);
  assign w_wr_div  = we & (addr[3:2] == 2'd3);
  assign w_flush   = w_wr_ctrl & wd[1];

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  // Flush suppresses the pop too, so the flushed head never reaches the shifter.
  assign w_can_pop = ~w_empty & ~w_flush;
  assign w_push    = w_wr_data & ~w_flush & (~w_full | w_pop);
  assign w_head    = r_mem[r_rptr];
  assign w_div_m1  = (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
  assign w_tick    = (r_timer == 16'd0);
  assign w_ien_nxt = w_wr_ctrl ? wd[0] : r_ien;
  assign w_cnt5    = 5'(r_count);
  assign w_unused  = ^{addr[31:4], addr[1:0], wd[31:16]};

  assign tx  = r_tx;
  assign irq = r_irq;

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush)
      w_count_nxt = '0;
    else if (w_push & ~w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (~w_push & w_pop)
      w_count_nxt = r_count - 1'b1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_pop        = 1'b0;
    if (r_state != S_IDLE && !w_tick)
      w_timer_nxt = r_timer - 16'd1;
    case (r_state)
      S_IDLE: begin
        if (w_can_pop) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_par_nxt   = ^w_head;
          w_timer_nxt = w_div_m1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_bitcnt_nxt = 3'd0;
          w_timer_nxt  = w_div_m1;
          w_state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_timer_nxt = w_div_m1;
          if (r_bitcnt == 3'd7) begin
`ifdef BUS_UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            w_shift_nxt  = {1'b0, r_shift[7:1]};
          end
        end
      end
`ifdef BUS_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_timer_nxt = w_div_m1;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          // Back-to-back frames: reload straight into START with no idle gap.
          if (w_can_pop) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_par_nxt   = ^w_head;
            w_timer_nxt = w_div_m1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef BUS_UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = w_par_nxt ^ w_odd;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  assign w_irq_nxt = w_ien_nxt & (w_count_nxt == '0) & (w_state_nxt == S_IDLE);

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= wd[7:0];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_ien    <= 1'b0;
      r_div    <= DIV_RESET;
      r_state  <= S_IDLE;
      r_timer  <= 16'd0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_irq    <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
      if (w_wr_stat)
        r_ovf <= 1'b0;
      else if (w_wr_data & ~w_flush & w_full & ~w_pop)
        r_ovf <= 1'b1;
      r_ien <= w_ien_nxt;
      if (w_wr_div)
        r_div <= wd[15:0];
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_par    <= w_par_nxt;
      r_tx     <= w_tx_nxt;
      r_irq    <= w_irq_nxt;
    end
  end

`ifdef BUS_UART_TX_PARITY_EN
  logic r_odd;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      r_odd <= 1'b0;
    else if (w_wr_ctrl)
      r_odd <= wd[2];
  end
  assign w_odd = r_odd;
`else
  assign w_odd = 1'b0;
`endif

  always_comb begin
    rd = 32'd0;
    case (addr[3:2])
      2'd1:    rd = {23'd0, w_cnt5, r_ovf, (r_state != S_IDLE), w_empty, w_full};
      2'd2:    rd = {29'd0, w_odd, 1'b0, r_ien};
      2'd3:    rd = {16'd0, r_div};
      default: rd = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed and randomized checks of bus_uart_tx against a frame-level reference model.
module tb_bus_uart_tx;

  localparam int DEPTH = 8;
`ifdef BUS_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] addr, wd, rd;
  logic        we, irq, tx;

  int          errors = 0;
  int          checks = 0;
  bit          m_odd = 1'b0;
  logic [31:0] st;
  logic [7:0]  q[$];
  logic [7:0]  bb;
  int          dv, n, sk;

  always #5 clk = ~clk;

  bus_uart_tx dut (
    .clk (clk),
    .clr (clr),
    .addr(addr),
    .we  (we),
    .wd  (wd),
    .rd  (rd),
    .irq (irq),
    .tx  (tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected STATUS word from queue occupancy and flags.
  function automatic logic [31:0] status_word(int count, bit ovf, bit busy);
    logic [31:0] s;
    s = 32'(count) << 4;
    if (ovf)          s = s | 32'h8;
    if (busy)         s = s | 32'h4;
    if (count == 0)   s = s | 32'h2;
    if (count == DEPTH) s = s | 32'h1;
    return s;
  endfunction

  // Serial line level for bit slot idx of a frame carrying byte b.
  function automatic bit frame_bit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (NBITS == 11 && idx == 9) return (^b) ^ m_odd;
    return 1'b1;
  endfunction

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  // Called just after the edge on which the frame began (t=0) or skip clocks later.
  task automatic check_frame(input logic [7:0] b, input int div, input int skip, input string tag);
    int de;
    logic [31:0] s;
    de = (div == 0) ? 1 : div;
    for (int t = skip; t < NBITS * de; t++) begin
      check($sformatf("%s.tx%0d", tag, t), 32'(tx), 32'(frame_bit(b, t / de)));
      if (t % de == 0) begin
        rd_reg(32'h4, s);
        check($sformatf("%s.busy%0d", tag, t), 32'(s[2]), 32'd1);
        check($sformatf("%s.irq%0d", tag, t), 32'(irq), 32'd0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    clr = 1'b0; we = 1'b0; addr = 32'd0; wd = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.tx", 32'(tx), 32'd1);
    check("rst.irq", 32'(irq), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    rd_reg(32'h0, st); check("rst.data", st, 32'd0);
    rd_reg(32'h4, st); check("rst.status", st, status_word(0, 0, 0));
    rd_reg(32'h8, st); check("rst.ctrl", st, 32'd0);
    rd_reg(32'hC, st); check("rst.div", st, 32'd2604);

    // Single 0x55 frame, DIV=4, ien=0
    bus_write(32'hC, 32'd4);
    bus_write(32'h0, 32'h55);
    @(posedge clk); #1;
    check_frame(8'h55, 4, 0, "f55");
    check("f55.idle_tx", 32'(tx), 32'd1);
    rd_reg(32'h4, st); check("f55.status", st, status_word(0, 0, 0));

    // Back-to-back frames with interrupt enabled
    bus_write(32'h8, 32'd1);
    bus_write(32'hC, 32'd2);
    check("b2b.irq_idle", 32'(irq), 32'd1);
    bus_write(32'h0, 32'hA5);
    bus_write(32'h0, 32'h3C);
    check("b2b.irq_push", 32'(irq), 32'd0);
    rd_reg(32'h4, st); check("b2b.count1", st, status_word(1, 0, 1));
    check_frame(8'hA5, 2, 0, "fA5");
    rd_reg(32'h4, st); check("b2b.count0", st, status_word(0, 0, 1));
    check_frame(8'h3C, 2, 0, "f3C");
    @(posedge clk); #1;
    check("b2b.irq_done", 32'(irq), 32'd1);
    bus_write(32'h8, 32'd0);
    @(posedge clk); #1;
    check("b2b.irq_ien0", 32'(irq), 32'd0);

    // Randomized bursts, DIV in 0..3 (0 behaves as 1)
    for (int r = 0; r < 4; r++) begin
      dv = int'($urandom_range(0, 3));
      n  = int'($urandom_range(1, 4));
      q.delete();
      bus_write(32'hC, 32'(dv));
      for (int i = 0; i < n; i++) begin
        bb = 8'($urandom);
        q.push_back(bb);
        bus_write(32'h0, {24'd0, bb});
      end
      if (n == 1) begin
        @(posedge clk); #1;
        sk = 0;
      end else begin
        sk = n - 2;
      end
      for (int i = 0; i < n; i++) begin
        check_frame(q[i], dv, sk, $sformatf("rnd%0d.%0d", r, i));
        sk = 0;
      end
      check($sformatf("rnd%0d.idle_tx", r), 32'(tx), 32'd1);
      rd_reg(32'h4, st); check($sformatf("rnd%0d.status", r), st, status_word(0, 0, 0));
    end

    // Flush mid-frame: current frame completes, queued bytes are discarded
    bus_write(32'hC, 32'd3);
    q.delete();
    for (int i = 0; i < 3; i++) begin
      bb = 8'($urandom);
      q.push_back(bb);
      bus_write(32'h0, {24'd0, bb});
    end
    bus_write(32'h8, 32'h2);
    rd_reg(32'h4, st); check("flush.status", st, status_word(0, 0, 1));
    check_frame(q[0], 3, 2, "fflush");
    for (int i = 0; i < 40; i++) begin
      check($sformatf("flush.quiet%0d", i), 32'(tx), 32'd1);
      @(posedge clk); #1;
    end
    rd_reg(32'h4, st); check("flush.idle", st, status_word(0, 0, 0));

    // Fill to full while the shifter is busy, then overflow
    bus_write(32'hC, 32'd1000);
    for (int i = 0; i < 9; i++) bus_write(32'h0, 32'($urandom_range(0, 255)));
    rd_reg(32'h4, st); check("ovf.full", st, status_word(8, 0, 1));
    bus_write(32'h0, 32'h99);
    rd_reg(32'h4, st); check("ovf.set", st, status_word(8, 1, 1));
    bus_write(32'h4, 32'd0);
    rd_reg(32'h4, st); check("ovf.clear", st, status_word(8, 0, 1));
    check("ovf.tx_start", 32'(tx), 32'd0);
    clr = 1'b0;
    #1;
    check("clr1.tx", 32'(tx), 32'd1);
    check("clr1.irq", 32'(irq), 32'd0);
    #2;
    clr = 1'b1;
    rd_reg(32'h4, st); check("clr1.status", st, status_word(0, 0, 0));
    rd_reg(32'hC, st); check("clr1.div", st, 32'd2604);

    // Asynchronous reset drops irq and tx without a clock edge
    bus_write(32'h8, 32'd1);
    @(posedge clk); #1;
    check("clr2.irq_before", 32'(irq), 32'd1);
    clr = 1'b0;
    #1;
    check("clr2.irq", 32'(irq), 32'd0);
    #1;
    clr = 1'b1;
    bus_write(32'hC, 32'd4);
    bus_write(32'h0, 32'h00);
    @(posedge clk); #1;
    repeat (6) begin @(posedge clk); #1; end
    check("clr3.tx_data", 32'(tx), 32'd0);
    clr = 1'b0;
    #1;
    check("clr3.tx", 32'(tx), 32'd1);
    check("clr3.irq", 32'(irq), 32'd0);
    #1;
    clr = 1'b1;
    rd_reg(32'hC, st); check("clr3.div", st, 32'd2604);
    rd_reg(32'h4, st); check("clr3.status", st, 32'h2);
    rd_reg(32'h8, st); check("clr3.ctrl", st, 32'd0);

`ifdef BUS_UART_TX_PARITY_EN
    bus_write(32'hC, 32'd2);
    m_odd = 1'b0;
    bus_write(32'h0, 32'h07);
    @(posedge clk); #1;
    check_frame(8'h07, 2, 0, "par_even");
    bus_write(32'h8, 32'h4);
    m_odd = 1'b1;
    rd_reg(32'h8, st); check("par.ctrl", st, 32'h4);
    bus_write(32'h0, 32'h07);
    @(posedge clk); #1;
    check_frame(8'h07, 2, 0, "par_odd");
    check("par.idle_tx", 32'(tx), 32'd1);
`else
    bus_write(32'h8, 32'h4);
    rd_reg(32'h8, st); check("nopar.ctrl", st, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
